// File: rtl/router_port_pkg.sv
// Shared router definitions: packet type and link geometry.
package router_port_pkg;

  localparam int PKT_BYTES = 4;
  localparam int BYTE_W    = 8;

  // byte[3] travels first on the byte-serial link, byte[0] last
  typedef logic [PKT_BYTES-1:0][BYTE_W-1:0] pkt_t;

endpackage

// File: rtl/router_port_txq.sv
// Outbound packet queue: power-of-two FIFO of pkt_t with a registered ready.
module router_port_txq
  import router_port_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic clock,
  input  logic reset_n,
  input  logic push,
  input  pkt_t push_pkt,
  input  logic pop,
  output pkt_t pop_pkt,
  output logic full,
  output logic empty,
  output logic ready
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  pkt_t          mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [AW:0]   count_r;
  logic [AW:0]   count_next_s;
  logic          ready_r;
  logic          do_push_s;
  logic          do_pop_s;

  assign full    = (count_r == FULL_CNT);
  assign empty   = (count_r == {(AW+1){1'b0}});
  assign ready   = ready_r;
  assign pop_pkt = mem_r[rd_ptr_r];

  // Qualify push/pop and compute the next occupancy
  always_comb begin
    do_push_s    = push && (!full || pop);
    do_pop_s     = pop && !empty;
    count_next_s = count_r;
    case ({do_push_s, do_pop_s})
      2'b10:   count_next_s = count_r + CNT_ONE;
      2'b01:   count_next_s = count_r - CNT_ONE;
      default: count_next_s = count_r;
    endcase
  end

  // Storage array; contents are don't-care while the slot is unoccupied
  always_ff @(posedge clock) begin
    if (do_push_s) begin
      mem_r[wr_ptr_r] <= push_pkt;
    end
  end

  // Pointers, occupancy and ready (ready drops the cycle after the filling push)
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {(AW+1){1'b0}};
      ready_r  <= 1'b1;
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      count_r <= count_next_s;
      ready_r <= (count_next_s != FULL_CNT);
    end
  end

endmodule

// File: rtl/router_port.sv
// Router-side endpoint of the node/router byte-serial link: deserializes
// node packets toward the core and serializes core packets toward the node.
module router_port
  import router_port_pkg::*;
#(
  parameter int TXQ_DEPTH = 2,
  parameter int CNT_W     = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  output logic             free_to_node,
  input  logic             put_from_node,
  input  logic [7:0]       payload_from_node,
  output logic             put_to_node,
  output logic [7:0]       payload_to_node,
  input  logic             free_from_node,
  output pkt_t             rx_pkt,
  output logic             rx_pkt_valid,
  input  logic             rx_pkt_ready,
  input  pkt_t             tx_pkt,
  input  logic             tx_pkt_valid,
  output logic             tx_pkt_ready,
  output logic             rx_err,
  output logic [CNT_W-1:0] rx_count,
  output logic [CNT_W-1:0] tx_count
);

  typedef enum logic [1:0] {R_IDLE = 2'd0, R_RECV = 2'd1, R_HOLD = 2'd2} rx_state_t;
  typedef enum logic [1:0] {T_IDLE = 2'd0, T_SEND = 2'd1, T_GAP = 2'd2} tx_state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  // ---------------- RX side ----------------
  rx_state_t        rx_state_r;
  logic [1:0]       rx_idx_r;
  pkt_t             rx_asm_r;
  pkt_t             rx_pkt_r;
  logic             rx_valid_r;
  logic             free_r;
  logic             rx_err_r;
  logic [CNT_W-1:0] rx_count_r;

  assign free_to_node = free_r;
  assign rx_pkt       = rx_pkt_r;
  assign rx_pkt_valid = rx_valid_r;
  assign rx_err       = rx_err_r;
  assign rx_count     = rx_count_r;

  // RX FSM: assemble 4 bytes, hold the packet for the core, flag broken bursts
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rx_state_r <= R_IDLE;
      rx_idx_r   <= 2'd0;
      rx_asm_r   <= '0;
      rx_pkt_r   <= '0;
      rx_valid_r <= 1'b0;
      free_r     <= 1'b1;
      rx_err_r   <= 1'b0;
      rx_count_r <= {CNT_W{1'b0}};
    end else begin
      rx_err_r <= 1'b0;
      case (rx_state_r)
        R_IDLE: begin
          if (put_from_node) begin
            rx_asm_r[3] <= payload_from_node;
            rx_idx_r    <= 2'd1;
            free_r      <= 1'b0;
            rx_state_r  <= R_RECV;
          end
        end
        R_RECV: begin
          if (put_from_node) begin
            if (rx_idx_r == 2'd3) begin
              rx_pkt_r   <= {rx_asm_r[3], rx_asm_r[2], rx_asm_r[1], payload_from_node};
              rx_valid_r <= 1'b1;
              rx_state_r <= R_HOLD;
            end else begin
              rx_asm_r[2'd3 - rx_idx_r] <= payload_from_node;
              rx_idx_r <= rx_idx_r + 2'd1;
            end
          end else begin
            // burst ended early: drop the partial packet
            rx_err_r   <= 1'b1;
            free_r     <= 1'b1;
            rx_state_r <= R_IDLE;
          end
        end
        R_HOLD: begin
          if (put_from_node) begin
            // extra byte while holding: drop it, keep the held packet
            rx_err_r <= 1'b1;
          end
          if (rx_pkt_ready) begin
            rx_valid_r <= 1'b0;
            rx_count_r <= rx_count_r + CNT_ONE;
            free_r     <= 1'b1;
            rx_state_r <= R_IDLE;
          end
        end
        default: begin
          rx_valid_r <= 1'b0;
          free_r     <= 1'b1;
          rx_state_r <= R_IDLE;
        end
      endcase
    end
  end

  // ---------------- TX side ----------------
  tx_state_t        tx_state_r;
  logic [1:0]       tx_cnt_r;
  pkt_t             tx_shift_r;
  logic             put_r;
  logic [7:0]       payload_r;
  logic [CNT_W-1:0] tx_count_r;
  logic             txq_push_s;
  logic             txq_pop_s;
  pkt_t             txq_pkt_s;
  logic             txq_full_s;
  logic             txq_empty_s;
  logic             txq_ready_s;

  assign put_to_node     = put_r;
  assign payload_to_node = payload_r;
  assign tx_count        = tx_count_r;
  assign tx_pkt_ready    = txq_ready_s;
  assign txq_push_s      = tx_pkt_valid && txq_ready_s;

  router_port_txq #(
    .DEPTH (TXQ_DEPTH)
  ) u_txq (
    .clock    (clock),
    .reset_n  (reset_n),
    .push     (txq_push_s),
    .push_pkt (tx_pkt),
    .pop      (txq_pop_s),
    .pop_pkt  (txq_pkt_s),
    .full     (txq_full_s),
    .empty    (txq_empty_s),
    .ready    (txq_ready_s)
  );

  // Pop decision: a new packet may start from idle, or right at the end of
  // the gap so back-to-back packets keep a 5-cycle period
  always_comb begin
    if ((tx_state_r == T_IDLE || tx_state_r == T_GAP) && !txq_empty_s && free_from_node) begin
      txq_pop_s = 1'b1;
    end else begin
      txq_pop_s = 1'b0;
    end
  end

  // TX FSM: 4 byte cycles, one idle gap, then next packet
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      tx_state_r <= T_IDLE;
      tx_cnt_r   <= 2'd0;
      tx_shift_r <= '0;
      put_r      <= 1'b0;
      payload_r  <= 8'h00;
      tx_count_r <= {CNT_W{1'b0}};
    end else begin
      case (tx_state_r)
        T_IDLE, T_GAP: begin
          if (txq_pop_s) begin
            tx_shift_r <= txq_pkt_s;
            put_r      <= 1'b1;
            payload_r  <= txq_pkt_s[3];
            tx_cnt_r   <= 2'd0;
            tx_state_r <= T_SEND;
          end else begin
            put_r      <= 1'b0;
            payload_r  <= 8'h00;
            tx_state_r <= T_IDLE;
          end
        end
        T_SEND: begin
          if (tx_cnt_r == 2'd3) begin
            put_r      <= 1'b0;
            payload_r  <= 8'h00;
            tx_count_r <= tx_count_r + CNT_ONE;
            tx_state_r <= T_GAP;
          end else begin
            put_r     <= 1'b1;
            payload_r <= tx_shift_r[2'd2 - tx_cnt_r];
            tx_cnt_r  <= tx_cnt_r + 2'd1;
          end
        end
        default: begin
          put_r      <= 1'b0;
          payload_r  <= 8'h00;
          tx_state_r <= T_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_router_port.sv
// Self-checking bench for router_port: RX vector table plus TX sequences.
module tb_router_port;
  import router_port_pkg::*;

  logic        clock;
  logic        reset_n;
  logic        free_to_node;
  logic        put_from_node;
  logic [7:0]  payload_from_node;
  logic        put_to_node;
  logic [7:0]  payload_to_node;
  logic        free_from_node;
  pkt_t        rx_pkt;
  logic        rx_pkt_valid;
  logic        rx_pkt_ready;
  pkt_t        tx_pkt;
  logic        tx_pkt_valid;
  logic        tx_pkt_ready;
  logic        rx_err;
  logic [15:0] rx_count;
  logic [15:0] tx_count;

  int total;
  int bad;

  router_port #(.TXQ_DEPTH(2), .CNT_W(16)) dut (
    .clock             (clock),
    .reset_n           (reset_n),
    .free_to_node      (free_to_node),
    .put_from_node     (put_from_node),
    .payload_from_node (payload_from_node),
    .put_to_node       (put_to_node),
    .payload_to_node   (payload_to_node),
    .free_from_node    (free_from_node),
    .rx_pkt            (rx_pkt),
    .rx_pkt_valid      (rx_pkt_valid),
    .rx_pkt_ready      (rx_pkt_ready),
    .tx_pkt            (tx_pkt),
    .tx_pkt_valid      (tx_pkt_valid),
    .tx_pkt_ready      (tx_pkt_ready),
    .rx_err            (rx_err),
    .rx_count          (rx_count),
    .tx_count          (tx_count)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  typedef struct {
    logic        put;
    logic [7:0]  data;
    logic        rdy;
    logic        e_free;
    logic        e_valid;
    logic        e_err;
    logic [31:0] e_pkt;
  } rx_vec_t;

  rx_vec_t vecs [17];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk_tx(input string nm, input logic p, input logic [7:0] b);
    chk({nm, "_put"}, {31'd0, put_to_node}, {31'd0, p});
    chk({nm, "_byte"}, {24'd0, payload_to_node}, {24'd0, b});
  endtask

  // Check the remaining bytes first_k..0 of a packet, then the gap cycle
  task automatic run_pkt(input pkt_t p, input int first_k);
    for (int k = first_k; k >= 0; k--) begin
      tick();
      chk_tx("tx_byte", 1'b1, p[k]);
    end
    tick();
    chk_tx("tx_gap", 1'b0, 8'h00);
  endtask

  initial begin
    pkt_t pa, pb, pc, pd;
    total = 0;
    bad   = 0;

    // step: inputs before the edge, expected outputs after it
    vecs[0]  = '{1'b1, 8'hDE, 1'b0, 1'b0, 1'b0, 1'b0, 32'h00000000};
    vecs[1]  = '{1'b1, 8'hAD, 1'b0, 1'b0, 1'b0, 1'b0, 32'h00000000};
    vecs[2]  = '{1'b1, 8'hBE, 1'b0, 1'b0, 1'b0, 1'b0, 32'h00000000};
    vecs[3]  = '{1'b1, 8'hEF, 1'b0, 1'b0, 1'b1, 1'b0, 32'hDEADBEEF};
    vecs[4]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 32'hDEADBEEF};
    vecs[5]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 32'hDEADBEEF};
    vecs[6]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 32'hDEADBEEF};
    vecs[7]  = '{1'b1, 8'hAA, 1'b0, 1'b0, 1'b0, 1'b0, 32'hDEADBEEF};
    vecs[8]  = '{1'b1, 8'hBB, 1'b0, 1'b0, 1'b0, 1'b0, 32'hDEADBEEF};
    vecs[9]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 32'hDEADBEEF};
    vecs[10] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 32'hDEADBEEF};
    vecs[11] = '{1'b1, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0, 32'hDEADBEEF};
    vecs[12] = '{1'b1, 8'h02, 1'b0, 1'b0, 1'b0, 1'b0, 32'hDEADBEEF};
    vecs[13] = '{1'b1, 8'h03, 1'b0, 1'b0, 1'b0, 1'b0, 32'hDEADBEEF};
    vecs[14] = '{1'b1, 8'h04, 1'b0, 1'b0, 1'b1, 1'b0, 32'h01020304};
    vecs[15] = '{1'b1, 8'h55, 1'b0, 1'b0, 1'b1, 1'b1, 32'h01020304};
    vecs[16] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 32'h01020304};

    reset_n           = 1'b0;
    put_from_node     = 1'b0;
    payload_from_node = 8'h00;
    rx_pkt_ready      = 1'b0;
    tx_pkt            = '0;
    tx_pkt_valid      = 1'b0;
    free_from_node    = 1'b1;
    #18;

    // reset values
    chk("rst_free", {31'd0, free_to_node}, 32'd1);
    chk("rst_put", {31'd0, put_to_node}, 32'd0);
    chk("rst_payload", {24'd0, payload_to_node}, 32'd0);
    chk("rst_rx_pkt", rx_pkt, 32'd0);
    chk("rst_rx_valid", {31'd0, rx_pkt_valid}, 32'd0);
    chk("rst_tx_ready", {31'd0, tx_pkt_ready}, 32'd1);
    chk("rst_rx_err", {31'd0, rx_err}, 32'd0);
    chk("rst_rx_count", {16'd0, rx_count}, 32'd0);
    chk("rst_tx_count", {16'd0, tx_count}, 32'd0);
    #5;
    reset_n = 1'b1;

    // RX table: good burst, held packet, short burst, good burst, extra byte
    for (int i = 0; i < 17; i++) begin
      put_from_node     = vecs[i].put;
      payload_from_node = vecs[i].data;
      rx_pkt_ready      = vecs[i].rdy;
      tick();
      chk($sformatf("rx%0d_free", i), {31'd0, free_to_node}, {31'd0, vecs[i].e_free});
      chk($sformatf("rx%0d_valid", i), {31'd0, rx_pkt_valid}, {31'd0, vecs[i].e_valid});
      chk($sformatf("rx%0d_err", i), {31'd0, rx_err}, {31'd0, vecs[i].e_err});
      chk($sformatf("rx%0d_pkt", i), rx_pkt, vecs[i].e_pkt);
      if (i == 6) chk("rx_count_1", {16'd0, rx_count}, 32'd1);
    end
    chk("rx_count_2", {16'd0, rx_count}, 32'd2);
    put_from_node = 1'b0;
    rx_pkt_ready  = 1'b0;

    // single TX packet, free already high
    pa = 32'h12345678;
    tx_pkt = pa;
    tx_pkt_valid = 1'b1;
    tick();
    tx_pkt_valid = 1'b0;
    chk_tx("tx1_accept", 1'b0, 8'h00);
    chk("tx1_ready", {31'd0, tx_pkt_ready}, 32'd1);
    run_pkt(pa, 3);
    chk("tx_count_1", {16'd0, tx_count}, 32'd1);
    tick();
    chk_tx("tx1_idle", 1'b0, 8'h00);

    // three packets, queue fills while free is low, then 5-cycle period
    pa = 32'hA1A2A3A4;
    pb = 32'hB1B2B3B4;
    pc = 32'hC1C2C3C4;
    free_from_node = 1'b0;
    tx_pkt = pa;
    tx_pkt_valid = 1'b1;
    tick();
    chk("tx3_ready_a", {31'd0, tx_pkt_ready}, 32'd1);
    tx_pkt = pb;
    tick();
    chk("tx3_ready_full", {31'd0, tx_pkt_ready}, 32'd0);
    chk_tx("tx3_wait", 1'b0, 8'h00);
    tx_pkt = pc;
    free_from_node = 1'b1;
    tick();
    chk_tx("tx3_a3", 1'b1, pa[3]);
    chk("tx3_ready_pop", {31'd0, tx_pkt_ready}, 32'd1);
    tick();
    chk_tx("tx3_a2", 1'b1, pa[2]);
    chk("tx3_ready_refull", {31'd0, tx_pkt_ready}, 32'd0);
    tx_pkt_valid = 1'b0;
    run_pkt(pa, 1);
    run_pkt(pb, 3);
    run_pkt(pc, 3);
    chk("tx_count_4", {16'd0, tx_count}, 32'd4);

    // free held low for 10 cycles with one packet queued
    pd = 32'hD1D2D3D4;
    free_from_node = 1'b0;
    tx_pkt = pd;
    tx_pkt_valid = 1'b1;
    tick();
    tx_pkt_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk_tx("txfree_hold", 1'b0, 8'h00);
    end
    free_from_node = 1'b1;
    run_pkt(pd, 3);
    chk("tx_count_5", {16'd0, tx_count}, 32'd5);

    // reset during the 3rd byte with a second packet still queued
    pa = 32'hCAFEF00D;
    pb = 32'h0BADC0DE;
    free_from_node = 1'b0;
    tx_pkt = pa;
    tx_pkt_valid = 1'b1;
    tick();
    tx_pkt = pb;
    tick();
    tx_pkt_valid = 1'b0;
    free_from_node = 1'b1;
    tick();
    chk_tx("txr_b3", 1'b1, pa[3]);
    tick();
    chk_tx("txr_b2", 1'b1, pa[2]);
    tick();
    chk_tx("txr_b1", 1'b1, pa[1]);
    reset_n = 1'b0;
    #1;
    chk_tx("txr_async", 1'b0, 8'h00);
    chk("txr_count", {16'd0, tx_count}, 32'd0);
    chk("txr_ready", {31'd0, tx_pkt_ready}, 32'd1);
    chk("txr_rx_count", {16'd0, rx_count}, 32'd0);
    chk("txr_free", {31'd0, free_to_node}, 32'd1);
    #2;
    reset_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk_tx("txr_empty", 1'b0, 8'h00);
    end
    chk("txr_count_after", {16'd0, tx_count}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
